// File: rtl/clk_ctrl_pkg.sv
// Shared constants for the clock divider controller: FSM state encodings
// and default widths for the divide value and the edge counter.
package clk_ctrl_pkg;

   // Controller states (two-bit encoding; 2'd3 is unused and recovers to idle)
   localparam logic [1:0] ST_IDLE     = 2'd0;
   localparam logic [1:0] ST_RUN      = 2'd1;
   localparam logic [1:0] ST_STOPPING = 2'd2;

   // Default widths
   localparam int DIV_W_DEF = 8;
   localparam int CNT_W_DEF = 16;

endpackage

// File: rtl/clk_div_counter.sv
// Loadable down-counter used to time each half-period of clk_out.
// tc flags a count of zero; the owner reloads on tc, so the counter never
// needs to wrap in normal use.
module clk_div_counter #(
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         en,
   input  logic         load,
   input  logic [W-1:0] load_val,
   output logic         tc
);

   logic [W-1:0] count_reg;

   // Load has priority over counting; counting only while enabled
   always_ff @(posedge clk) begin
      if (reset) begin
         count_reg <= '0;
      end else if (load) begin
         count_reg <= load_val;
      end else if (en) begin
         count_reg <= count_reg - W'(1);
      end
   end

   assign tc = (count_reg == '0);

endmodule

// File: rtl/clk_div_ctrl.sv
// Run-time clock divider / gate. Produces a registered, divided clk_out with
// a one-cycle tick on each rising edge, and sequences start/stop so that a
// stop request always lets the current high half finish (no runt pulses).
module clk_div_ctrl
   import clk_ctrl_pkg::*;
#(
   parameter int DIV_W   = DIV_W_DEF,
   parameter int CNT_W   = CNT_W_DEF,
   parameter int DIV_RST = 1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic             stop,
   input  logic             load,
   input  logic [DIV_W-1:0] div_in,
   output logic             clk_out,
   output logic             tick,
   output logic             busy,
   output logic [DIV_W-1:0] div_q,
   output logic [CNT_W-1:0] edges_q
);

   logic [1:0]       state_reg,  state_next;
   logic             clk_reg,    clk_next;
   logic             tick_reg,   tick_next;
   logic [CNT_W-1:0] edges_reg,  edges_next;
   logic [DIV_W-1:0] div_reg,    div_next;
   logic             cnt_load;
   logic             cnt_en;
   logic             cnt_tc;
   logic             go;

   // A run request only counts when stop is not asserted alongside it
   assign go = start & ~stop;

   // Next-state logic: divide value update, FSM, output clock and edge count
   always_comb begin
      // A divide value of zero is meaningless; store it as one
      div_next   = div_reg;
      if (load) begin
         div_next = (div_in == '0) ? DIV_W'(1) : div_in;
      end
      state_next = state_reg;
      clk_next   = clk_reg;
      tick_next  = 1'b0;
      edges_next = edges_reg;
      cnt_load   = 1'b0;
      cnt_en     = 1'b0;

      case (state_reg)
         ST_IDLE: begin
            clk_next = 1'b0;
            if (go) begin
               state_next = ST_RUN;
               cnt_load   = 1'b1;
               edges_next = '0;
            end
         end
         ST_RUN: begin
            if (stop && !clk_reg) begin
               // Already parked low: leave immediately without toggling
               state_next = ST_IDLE;
            end else begin
               cnt_en = 1'b1;
               if (stop) begin
                  state_next = ST_STOPPING;
               end
               if (cnt_tc) begin
                  clk_next = ~clk_reg;
                  cnt_load = 1'b1;
                  if (!clk_reg) begin
                     tick_next  = 1'b1;
                     edges_next = edges_reg + CNT_W'(1);
                  end else if (stop) begin
                     // High half ends on this very edge: nothing left to wait for
                     state_next = ST_IDLE;
                  end
               end
            end
         end
         ST_STOPPING: begin
            if (!clk_reg) begin
               // Cannot normally happen; park safely
               state_next = ST_IDLE;
               clk_next   = 1'b0;
            end else begin
               cnt_en = 1'b1;
               if (go) begin
                  state_next = ST_RUN;
               end
               if (cnt_tc) begin
                  clk_next = 1'b0;
                  cnt_load = 1'b1;
                  if (!go) begin
                     state_next = ST_IDLE;
                  end
               end
            end
         end
         default: begin
            state_next = ST_IDLE;
            clk_next   = 1'b0;
         end
      endcase
   end

   // Half-period timer; reloads with the (possibly just loaded) divide value
   clk_div_counter #(
      .W (DIV_W)
   ) u_counter (
      .clk      (clk),
      .reset    (reset),
      .en       (cnt_en),
      .load     (cnt_load),
      .load_val (div_next - DIV_W'(1)),
      .tc       (cnt_tc)
   );

   // State and output registers with synchronous reset
   always_ff @(posedge clk) begin
      if (reset) begin
         state_reg <= ST_IDLE;
         clk_reg   <= 1'b0;
         tick_reg  <= 1'b0;
         edges_reg <= '0;
         div_reg   <= DIV_W'(DIV_RST);
      end else begin
         state_reg <= state_next;
         clk_reg   <= clk_next;
         tick_reg  <= tick_next;
         edges_reg <= edges_next;
         div_reg   <= div_next;
      end
   end

   assign clk_out = clk_reg;
   assign tick    = tick_reg;
   assign busy    = (state_reg != ST_IDLE);
   assign div_q   = div_reg;
   assign edges_q = edges_reg;

endmodule
